mycpu_div: RTL and testbench

MYCPU_DIV -- requirements
Module: mycpu_div

---
 rtl/mycpu_div_pkg.sv | 29 ++
 rtl/mycpu_div.sv | 107 ++++++++++
 tb/tb_mycpu_div.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_div_pkg.sv
// Shared CPU definitions for the iterative divider: width, FSM encoding and
// sign helpers used when latching operands and fixing up results.
package mycpu_div_pkg;

  localparam int DIV_W = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DIV_W-1:0] apply_sign(input logic [DIV_W-1:0] mag,
                                                  input logic neg);
    logic signed [DIV_W-1:0] sval;
    sval = signed'(mag);
    return neg ? DIV_W'(-sval) : mag;
  endfunction

  // Magnitude of an operand: only signed operands with the top bit set flip.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v,
                                                 input logic is_signed);
    return apply_sign(v, is_signed & v[DIV_W-1]);
  endfunction

endpackage

// File: rtl/mycpu_div.sv
// Fixed-latency radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// Accept in cycle N, 32 iteration cycles, div_done pulses in cycle N+33.
module mycpu_div
  import mycpu_div_pkg::*;
#(
  parameter int DIV_W = mycpu_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] div_x,
  input  logic [DIV_W-1:0] div_y,
  input  logic             div_cancel,
  output logic             div_ready,
  output logic             div_busy,
  output logic             div_done,
  output logic [DIV_W-1:0] div_quot,
  output logic [DIV_W-1:0] div_rem
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0]     part_q;     // partial remainder
  logic [DIV_W-1:0]     dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [DIV_W-1:0]     dvs_q;      // divisor magnitude
  logic                 quot_neg_q;
  logic                 rem_neg_q;
  logic                 yzero_q;
  logic                 done_q;
  logic [DIV_W-1:0]     quot_q;
  logic [DIV_W-1:0]     rem_q;

  logic [DIV_W:0]       shifted;
  logic [DIV_W+1:0]     diff;
  logic                 borrow;
  logic [DIV_W-1:0]     part_d;
  logic [DIV_W-1:0]     dvd_d;
  logic                 unused_bits;

  // One restoring step: shift in the next dividend bit, try subtracting the divisor.
  always_comb begin
    shifted = {part_q, dvd_q[DIV_W-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    borrow  = diff[DIV_W+1];
    part_d  = borrow ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];
    dvd_d   = {dvd_q[DIV_W-2:0], ~borrow};
  end

  // Top bits only matter for the borrow; with a nonzero divisor the kept
  // remainder always fits, and with a zero divisor it degenerates into x.
  assign unused_bits = ^{shifted[DIV_W], diff[DIV_W]};

  // Control FSM with registered done pulse and results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (div_valid && !div_cancel) begin
            dvd_q      <= magnitude(div_x, div_signed);
            dvs_q      <= magnitude(div_y, div_signed);
            part_q     <= '0;
            quot_neg_q <= div_signed & (div_x[DIV_W-1] ^ div_y[DIV_W-1]);
            rem_neg_q  <= div_signed & div_x[DIV_W-1];
            yzero_q    <= (div_y == '0);
            cnt_q      <= '0;
            state_q    <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (div_cancel) begin
            cnt_q   <= '0;
            state_q <= DIV_IDLE;
          end else begin
            part_q <= part_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_q + DIV_CNT_W'(1);
            if (cnt_q == DIV_CNT_W'(DIV_W - 1)) begin
              // Remainder carries the dividend's sign; with y==0 it rebuilds x.
              quot_q  <= yzero_q ? '1 : apply_sign(dvd_d, quot_neg_q);
              rem_q   <= apply_sign(part_d, rem_neg_q);
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= DIV_DONE;
            end
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign div_ready = (state_q == DIV_IDLE);
  assign div_busy  = (state_q != DIV_IDLE);
  assign div_done  = done_q;
  assign div_quot  = quot_q;
  assign div_rem   = rem_q;

endmodule

// File: tb/tb_mycpu_div.sv
// Directed bench for mycpu_div: latency, arithmetic corners, cancel, reset, back-to-back.
module tb_mycpu_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_cancel;
  logic        div_ready;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mycpu_div u_div (
    .clk        (clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_signed (div_signed),
    .div_x      (div_x),
    .div_y      (div_y),
    .div_cancel (div_cancel),
    .div_ready  (div_ready),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  localparam int NV = 10;
  localparam logic        VS [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] VX [NV] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h12345678, 32'h12345678,
                                      32'hFFFFFF9C, 32'h00000064, 32'hFFFFFFFF, 32'h87654321, 32'h80000000};
  localparam logic [31:0] VY [NV] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
                                      32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
  localparam logic [31:0] VQ [NV] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                      32'h0000000E, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
  localparam logic [31:0] VR [NV] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h12345678, 32'h12345678,
                                      32'hFFFFFFFE, 32'h00000002, 32'h00000000, 32'h87654321, 32'h80000000};

  // Present a request in the current cycle; returns just after the accepting edge.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = s;
    div_x      = x;
    div_y      = y;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; div_valid = 1'b0; div_cancel = 1'b0;
    div_signed = 1'b0; div_x = '0; div_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", div_ready); end
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", div_busy); end
    checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", div_done); end
    checks++; if (div_quot !== 32'h0) begin errors++; $display("FAIL reset_quot got %h exp 0", div_quot); end
    checks++; if (div_rem !== 32'h0) begin errors++; $display("FAIL reset_rem got %h exp 0", div_rem); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned_latency();
    int dc = 0;
    issue(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        div_valid = 1'b0;
        checks++; if (div_busy !== 1'b1 || div_ready !== 1'b0) begin
          errors++; $display("FAIL calc_flags busy %b ready %b exp 1 0", div_busy, div_ready);
        end
      end
      if (div_done === 1'b1) dc = c;
    end
    checks++; if (dc != 33) begin errors++; $display("FAIL u100_7_latency got %0d exp 33", dc); end
    checks++; if (div_quot !== 32'h0000000E) begin errors++; $display("FAIL u100_7_quot got %h exp 0000000e", div_quot); end
    checks++; if (div_rem !== 32'h00000002) begin errors++; $display("FAIL u100_7_rem got %h exp 00000002", div_rem); end
    @(negedge clk);
    checks++; if (div_ready !== 1'b1 || div_done !== 1'b0) begin
      errors++; $display("FAIL u100_7_after ready %b done %b exp 1 0", div_ready, div_done);
    end
    repeat (5) @(negedge clk);
    checks++; if (div_quot !== 32'h0000000E || div_rem !== 32'h00000002) begin
      errors++; $display("FAIL hold got %h %h exp 0000000e 00000002", div_quot, div_rem);
    end
  endtask

  task automatic test_vectors();
    for (int v = 0; v < NV; v++) begin
      int dc = 0;
      issue(VS[v], VX[v], VY[v]);
      for (int c = 1; c <= 40 && dc == 0; c++) begin
        @(negedge clk);
        if (c == 1) div_valid = 1'b0;
        if (div_done === 1'b1) dc = c;
      end
      checks++; if (dc != 33) begin errors++; $display("FAIL vec%0d_latency got %0d exp 33", v, dc); end
      checks++; if (div_quot !== VQ[v]) begin errors++; $display("FAIL vec%0d_quot got %h exp %h", v, div_quot, VQ[v]); end
      checks++; if (div_rem !== VR[v]) begin errors++; $display("FAIL vec%0d_rem got %h exp %h", v, div_rem, VR[v]); end
    end
  endtask

  task automatic test_cancel();
    int dc = 0;
    int early = 0;
    issue(1'b0, 32'h00001000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) div_valid = 1'b0;
      if (c == 10) div_cancel = 1'b1;
      if (div_done === 1'b1) early++;
    end
    @(negedge clk);
    checks++; if (div_ready !== 1'b1 || div_busy !== 1'b0) begin
      errors++; $display("FAIL cancel_idle ready %b busy %b exp 1 0", div_ready, div_busy);
    end
    checks++; if (div_quot !== 32'h0 || div_rem !== 32'h80000000) begin
      errors++; $display("FAIL cancel_outputs got %h %h exp 00000000 80000000", div_quot, div_rem);
    end
    div_cancel = 1'b0; div_valid = 1'b1; div_signed = 1'b0; div_x = 32'd50; div_y = 32'd5;
    for (int c = 12; c <= 50 && dc == 0; c++) begin
      @(negedge clk);
      if (c == 12) div_valid = 1'b0;
      if (div_done === 1'b1) dc = c;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL cancel_no_done got %0d pulses exp 0", early); end
    checks++; if (dc != 44) begin errors++; $display("FAIL cancel_next_latency got %0d exp 44", dc); end
    checks++; if (div_quot !== 32'd10 || div_rem !== 32'd0) begin
      errors++; $display("FAIL cancel_next_result got %h %h exp 0000000a 00000000", div_quot, div_rem);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel_priority();
    int pulses = 0;
    @(negedge clk);
    div_valid = 1'b1; div_cancel = 1'b1; div_signed = 1'b0; div_x = 32'd9; div_y = 32'd3;
    @(negedge clk);
    checks++; if (div_ready !== 1'b1 || div_busy !== 1'b0) begin
      errors++; $display("FAIL cancel_prio ready %b busy %b exp 1 0", div_ready, div_busy);
    end
    div_valid = 1'b0; div_cancel = 1'b0;
    repeat (40) begin @(negedge clk); if (div_done === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL cancel_prio_done got %0d exp 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) div_valid = 1'b0;
      if (c == 20) begin reset = 1'b1; div_valid = 1'b1; div_cancel = 1'b1; end
      if (div_done === 1'b1) pulses++;
    end
    @(negedge clk);
    reset = 1'b0; div_valid = 1'b0; div_cancel = 1'b0;
    checks++; if (div_ready !== 1'b1 || div_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state ready %b busy %b exp 1 0", div_ready, div_busy);
    end
    checks++; if (div_quot !== 32'h0 || div_rem !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs got %h %h exp 0 0", div_quot, div_rem);
    end
    repeat (40) begin @(negedge clk); if (div_done === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_done got %0d exp 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int d1 = 0;
    int d2 = 0;
    int pulses = 0;
    issue(1'b0, 32'd1000, 32'd10);
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 1) begin div_x = 32'd77; div_y = 32'd7; end
      if (c == 34) begin
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready34 got %b exp 1", div_ready); end
      end
      if (c == 35) div_valid = 1'b0;
      if (div_done === 1'b1) begin
        pulses++;
        if (d1 == 0) begin
          d1 = c;
          checks++; if (div_quot !== 32'd100 || div_rem !== 32'd0) begin
            errors++; $display("FAIL b2b_first got %h %h exp 00000064 00000000", div_quot, div_rem);
          end
        end else if (d2 == 0) begin
          d2 = c;
          checks++; if (div_quot !== 32'd11 || div_rem !== 32'd0) begin
            errors++; $display("FAIL b2b_second got %h %h exp 0000000b 00000000", div_quot, div_rem);
          end
        end
      end
    end
    checks++; if (d1 != 33 || d2 != 67) begin errors++; $display("FAIL b2b_latency got %0d %0d exp 33 67", d1, d2); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
  endtask

  initial begin
    test_reset();
    test_unsigned_latency();
    test_vectors();
    test_cancel();
    test_cancel_priority();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
